// File: rtl/wb_retire_queue.sv
// In-order writeback retire queue: buffers MEM results and commits the head to regfile/CSR/trace.
// Optional WB_RETIRE_CNT_EN adds a 64-bit count of non-exception commits (retire_cnt).
module wb_retire_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic                in_gr_we,
  input  logic [4:0]          in_waddr,
  input  logic [DW-1:0]       in_wdata,
  input  logic                in_csr_re,
  input  logic                in_csr_we,
  input  logic [13:0]         in_csr_num,
  input  logic [31:0]         in_csr_wmask,
  input  logic [31:0]         in_csr_wvalue,
  input  logic                in_ertn,
  input  logic                in_ex,
  input  logic [5:0]          in_ecode,
  input  logic [8:0]          in_esubcode,
  input  logic [31:0]         in_vaddr,
  input  logic                retire_ready,
  input  logic [31:0]         csr_rvalue,
  output logic                rf_wen,
  output logic [4:0]          rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  output logic                csr_re,
  output logic                csr_we,
  output logic [13:0]         csr_num,
  output logic [31:0]         csr_wmask,
  output logic [31:0]         csr_wvalue,
  output logic                wb_ex,
  output logic                ertn_flush,
  output logic [31:0]         wb_pc,
  output logic [31:0]         wb_vaddr,
  output logic [5:0]          wb_ecode,
  output logic [8:0]          wb_esubcode,
  output logic [PTR_W:0]      occupancy,
  output logic [DW+40:0]      inst_retire
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]         retire_cnt
`endif
);

  typedef struct packed {
    logic [31:0]   pc;
    logic          gr_we;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
    logic          csr_re;
    logic          csr_we;
    logic [13:0]   csr_num;
    logic [31:0]   csr_wmask;
    logic [31:0]   csr_wvalue;
    logic          ertn;
    logic          ex;
    logic [5:0]    ecode;
    logic [8:0]    esubcode;
    logic [31:0]   vaddr;
  } entry_t;

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   occ_q;
  entry_t           mem_q [DEPTH];
  entry_t           head, in_entry;
  logic             head_valid, commit, flush_now, push;

  // Head decode, handshake and commit-side outputs
  always_comb begin
    head        = mem_q[head_q];
    head_valid  = (occ_q != '0);
    commit      = head_valid & retire_ready;
    flush_now   = commit & (head.ex | head.ertn);
    in_ready    = (occ_q < (PTR_W+1)'(DEPTH)) & ~flush_now;
    push        = in_valid & in_ready;

    rf_wen      = commit & head.gr_we & ~head.ex;
    rf_waddr    = '0;
    rf_wdata    = '0;
    csr_re      = 1'b0;
    csr_num     = '0;
    csr_we      = commit & head.csr_we & ~head.ex;
    csr_wmask   = '0;
    csr_wvalue  = '0;
    wb_ex       = commit & head.ex;
    ertn_flush  = commit & head.ertn & ~head.ex;
    wb_pc       = '0;
    wb_vaddr    = '0;
    wb_ecode    = '0;
    wb_esubcode = '0;
    if (head_valid) begin
      rf_waddr   = head.waddr;
      rf_wdata   = head.csr_re ? DW'(csr_rvalue) : head.wdata;
      csr_re     = head.csr_re;
      csr_num    = head.csr_num;
      csr_wmask  = head.csr_wmask;
      csr_wvalue = head.csr_wvalue;
      wb_pc      = head.pc;
      wb_vaddr   = head.vaddr;
      if (head.ex) begin
        wb_ecode    = head.ecode;
        wb_esubcode = head.esubcode;
      end
    end
    occupancy   = occ_q;
    inst_retire = {wb_pc, {4{rf_wen}}, rf_waddr, rf_wdata};
  end

  always_comb begin
    in_entry = '{pc: in_pc, gr_we: in_gr_we, waddr: in_waddr, wdata: in_wdata,
                 csr_re: in_csr_re, csr_we: in_csr_we, csr_num: in_csr_num,
                 csr_wmask: in_csr_wmask, csr_wvalue: in_csr_wvalue, ertn: in_ertn,
                 ex: in_ex, ecode: in_ecode, esubcode: in_esubcode, vaddr: in_vaddr};
  end

  // Pointers and occupancy; a flush retires the head and drops everything younger
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (flush_now) begin
      head_q <= head_q + PTR_W'(1);
      tail_q <= head_q + PTR_W'(1);
      occ_q  <= '0;
    end else begin
      if (commit) head_q <= head_q + PTR_W'(1);
      if (push)   tail_q <= tail_q + PTR_W'(1);
      if (push && !commit)      occ_q <= occ_q + (PTR_W+1)'(1);
      else if (!push && commit) occ_q <= occ_q - (PTR_W+1)'(1);
    end
  end

  // Payload storage needs no reset: entries are only read while occupancy says they are live
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_entry;
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   retire_cnt <= '0;
    else if (commit && !head.ex) retire_cnt <= retire_cnt + 64'd1;
  end
`else
  // Retire counter not built in this configuration
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// Table-driven bench for wb_retire_queue with a scoreboard of expected commits.
module tb_wb_retire_queue;
  localparam int DEPTH = 2;
  localparam int DW    = 32;

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
  } ent_t;

  typedef struct {
    logic valid;
    logic rr;
    ent_t e;
    logic exp_ready;
    int   exp_occ;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, in_gr_we = 1'b0, in_csr_re = 1'b0, in_csr_we = 1'b0;
  logic in_ertn = 1'b0, in_ex = 1'b0, retire_ready = 1'b0;
  logic [31:0] in_pc = '0, in_wdata = '0, in_csr_wmask = '0, in_csr_wvalue = '0, in_vaddr = '0;
  logic [4:0]  in_waddr = '0;
  logic [13:0] in_csr_num = '0;
  logic [5:0]  in_ecode = '0;
  logic [8:0]  in_esubcode = '0;
  logic [31:0] csr_rvalue;
  logic        rf_wen, csr_re, csr_we, wb_ex, ertn_flush;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wmask, csr_wvalue, wb_pc, wb_vaddr;
  logic [13:0] csr_num;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [1:0]  occupancy;
  logic [DW+40:0] inst_retire;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int n_cmp = 0, n_bad = 0;
  longint exp_cnt = 0;
  ent_t sb[$];
  vec_t vecs[$];
  ent_t cur_e;

  always #5 clk = ~clk;

  // Environment CSR file: fixed contents, one marker value at 0x005
  function automatic logic [31:0] fn_csr(input logic [13:0] num);
    return (num == 14'h005) ? 32'hDEADBEEF : ({18'h0, num} ^ 32'hA5A50000);
  endfunction
  assign csr_rvalue = fn_csr(csr_num);

  wb_retire_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gr_we(in_gr_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .in_csr_re(in_csr_re),
    .in_csr_we(in_csr_we), .in_csr_num(in_csr_num), .in_csr_wmask(in_csr_wmask),
    .in_csr_wvalue(in_csr_wvalue), .in_ertn(in_ertn), .in_ex(in_ex), .in_ecode(in_ecode),
    .in_esubcode(in_esubcode), .in_vaddr(in_vaddr), .retire_ready(retire_ready),
    .csr_rvalue(csr_rvalue), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .occupancy(occupancy), .inst_retire(inst_retire)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] wdata);
    ent_t e;
    e = '{pc: pc, gr_we: 1'b1, waddr: waddr, wdata: wdata, csr_re: 1'b0, csr_we: 1'b0,
          csr_num: 14'h0, csr_wmask: 32'h0, csr_wvalue: 32'h0, ertn: 1'b0, ex: 1'b0,
          ecode: 6'h0, esub: 9'h0, vaddr: 32'h0};
    return e;
  endfunction

  function automatic vec_t mkv(input logic valid, input logic rr, input ent_t e,
                               input logic exp_ready, input int exp_occ);
    vec_t v;
    v = '{valid: valid, rr: rr, e: e, exp_ready: exp_ready, exp_occ: exp_occ};
    return v;
  endfunction

  task automatic drive(input logic valid, input logic rr, input ent_t e);
    cur_e = e;
    in_valid = valid; retire_ready = rr;
    in_pc = e.pc; in_gr_we = e.gr_we; in_waddr = e.waddr; in_wdata = e.wdata;
    in_csr_re = e.csr_re; in_csr_we = e.csr_we; in_csr_num = e.csr_num;
    in_csr_wmask = e.csr_wmask; in_csr_wvalue = e.csr_wvalue; in_ertn = e.ertn;
    in_ex = e.ex; in_ecode = e.ecode; in_esubcode = e.esub; in_vaddr = e.vaddr;
  endtask

  // Compare commit-side outputs against the scoreboard head
  task automatic check_outputs();
    ent_t h;
    logic hv, cm, wen;
    logic [31:0] wd;
    hv = (sb.size() != 0);
    h  = hv ? sb[0] : mk(32'h0, 5'h0, 32'h0);
    cm = hv & retire_ready;
    wen = cm & h.gr_we & ~h.ex;
    wd = h.csr_re ? fn_csr(h.csr_num) : h.wdata;
    chk("rf_wen", 80'(rf_wen), 80'(wen));
    chk("wb_ex", 80'(wb_ex), 80'(cm & h.ex));
    chk("ertn_flush", 80'(ertn_flush), 80'(cm & h.ertn & ~h.ex));
    chk("csr_we", 80'(csr_we), 80'(cm & h.csr_we & ~h.ex));
    if (hv) begin
      chk("csr_re", 80'(csr_re), 80'(h.csr_re));
      chk("csr_num", 80'(csr_num), 80'(h.csr_num));
    end
    if (cm) begin
      chk("wb_pc", 80'(wb_pc), 80'(h.pc));
      chk("rf_waddr", 80'(rf_waddr), 80'(h.waddr));
      chk("rf_wdata", 80'(rf_wdata), 80'(wd));
      chk("wb_ecode", 80'(wb_ecode), 80'(h.ex ? h.ecode : 6'h0));
      chk("wb_esubcode", 80'(wb_esubcode), 80'(h.ex ? h.esub : 9'h0));
      chk("wb_vaddr", 80'(wb_vaddr), 80'(h.vaddr));
      chk("inst_retire", 80'(inst_retire), 80'({h.pc, {4{wen}}, h.waddr, wd}));
      if (h.csr_we && !h.ex) begin
        chk("csr_wmask", 80'(csr_wmask), 80'(h.csr_wmask));
        chk("csr_wvalue", 80'(csr_wvalue), 80'(h.csr_wvalue));
      end
    end else begin
      chk("inst_retire_wen", 80'(inst_retire[DW+8:DW+5]), 80'(4'h0));
    end
  endtask

  // Advance the reference queue by one clock
  task automatic model_step();
    logic hv, cm, fl, rdy;
    hv  = (sb.size() != 0);
    cm  = hv & retire_ready;
    fl  = cm && (sb[0].ex || sb[0].ertn);
    rdy = (sb.size() < DEPTH) && !fl;
    if (cm && !sb[0].ex) exp_cnt++;
    if (cm) sb.delete(0);
    if (fl) sb.delete();
    if (in_valid && rdy) sb.push_back(cur_e);
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v.valid, v.rr, v.e);
    @(negedge clk);
    chk("in_ready", 80'(in_ready), 80'(v.exp_ready));
    chk("occupancy", 80'(occupancy), 80'(v.exp_occ));
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    ent_t e, z;
    z = mk(32'h0, 5'h0, 32'h0);
    z.gr_we = 1'b0;

    // Back-to-back pushes into a stalled queue, then drain in order
    vecs.push_back(mkv(1, 0, mk(32'h1c000000, 5'd1, 32'h11), 1, 0));
    vecs.push_back(mkv(1, 0, mk(32'h1c000004, 5'd2, 32'h22), 1, 1));
    vecs.push_back(mkv(1, 0, mk(32'h1c000008, 5'd3, 32'h33), 0, 2));
    vecs.push_back(mkv(0, 1, z, 0, 2));
    vecs.push_back(mkv(0, 1, z, 1, 1));
    // Exception at head with a younger entry behind it
    e = mk(32'h1c000100, 5'd4, 32'h44); e.ex = 1; e.ecode = 6'h0B; e.esub = 9'h1A5; e.vaddr = 32'h1234;
    vecs.push_back(mkv(1, 0, e, 1, 0));
    vecs.push_back(mkv(1, 0, mk(32'h1c000104, 5'd6, 32'h66), 1, 1));
    vecs.push_back(mkv(0, 1, z, 0, 2));
    vecs.push_back(mkv(0, 1, z, 1, 0));
    // CSR read forwarded into rf_wdata
    e = mk(32'h1c000200, 5'd5, 32'h0); e.csr_re = 1; e.csr_num = 14'h005;
    vecs.push_back(mkv(1, 1, e, 1, 0));
    vecs.push_back(mkv(0, 1, z, 1, 1));
    // ertn flush discards a queued CSR write, then a standalone CSR write commits
    e = mk(32'h1c000300, 5'd0, 32'h0); e.gr_we = 0; e.ertn = 1;
    vecs.push_back(mkv(1, 0, e, 1, 0));
    e = mk(32'h1c000304, 5'd0, 32'h0); e.gr_we = 0; e.csr_we = 1; e.csr_num = 14'h6;
    e.csr_wmask = 32'hFF; e.csr_wvalue = 32'h55;
    vecs.push_back(mkv(1, 0, e, 1, 1));
    vecs.push_back(mkv(0, 1, z, 0, 2));
    e.pc = 32'h1c000308; e.csr_wvalue = 32'hA7;
    vecs.push_back(mkv(1, 1, e, 1, 0));
    vecs.push_back(mkv(0, 1, z, 1, 1));
    // Full queue refuses a push even while committing
    vecs.push_back(mkv(1, 0, mk(32'h1c000400, 5'd7, 32'h70), 1, 0));
    vecs.push_back(mkv(1, 0, mk(32'h1c000404, 5'd8, 32'h80), 1, 1));
    vecs.push_back(mkv(1, 1, mk(32'h1c000408, 5'd9, 32'h90), 0, 2));
    vecs.push_back(mkv(1, 1, mk(32'h1c00040c, 5'd10, 32'hA0), 1, 1));
    vecs.push_back(mkv(0, 1, z, 1, 1));
    // Steady push+commit at occupancy 1 across several pointer wraps
    vecs.push_back(mkv(1, 0, mk(32'h1c000500, 5'd11, 32'h500), 1, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mkv(1, 1, mk(32'h1c000500 + 32'(4 * i), 5'(11 + i), 32'h500 + 32'(i)), 1, 1));
    vecs.push_back(mkv(0, 1, z, 1, 1));

    // Reset state
    drive(0, 0, z);
    @(negedge clk);
    chk("rst_occupancy", 80'(occupancy), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_rf_wen", 80'(rf_wen), 80'(0));
    chk("rst_wb_ex", 80'(wb_ex), 80'(0));
    chk("rst_inst_retire", 80'(inst_retire), 80'(0));
    @(posedge clk); #1 rst = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", 80'(retire_cnt), 80'(exp_cnt));
`endif

    // Asynchronous reset with two entries queued
    apply_vec(mkv(1, 0, mk(32'h1c000600, 5'd1, 32'h1), 1, 0));
    apply_vec(mkv(1, 0, mk(32'h1c000604, 5'd2, 32'h2), 1, 1));
    drive(0, 1, z);
    chk("pre_rst_occupancy", 80'(occupancy), 80'(2));
    #2 rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_occupancy", 80'(occupancy), 80'(0));
    chk("mid_rst_in_ready", 80'(in_ready), 80'(1));
    chk("mid_rst_rf_wen", 80'(rf_wen), 80'(0));
`ifdef WB_RETIRE_CNT_EN
    chk("mid_rst_retire_cnt", 80'(retire_cnt), 80'(0));
`endif
    @(posedge clk); #1 rst = 1'b1;
    apply_vec(mkv(0, 1, z, 1, 0));
    apply_vec(mkv(1, 1, mk(32'h1c000700, 5'd3, 32'h3), 1, 0));
    apply_vec(mkv(0, 1, z, 1, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
